compare_arbiter: RTL
====================

# compare_arbiter

Shares one 32-bit equality comparator among several requesters, such as branch-resolution logic, the hazard unit and the debug port. It performs round-robin arbitration, captures operands, sequences one compare, and holds the result until the consumer accepts it. It sits beside the ID-stage datapath and delivers a single EQ/NE result per transaction, tagged with the requester id.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 32, operand width
- ID_W, 2, requester id width; must equal clog2(NUM_REQ)

- Clk  in  1  clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high reset; one clock, reset is synchronous and active-high
- ReqValid  in  NUM_REQ  per-requester request
- ReqReady  out  NUM_REQ  per-requester accept; combinational, at most one bit set
- ReqA  in  NUM_REQ*DATA_W  flattened operand A; requester i occupies bits [i*DATA_W +: DATA_W]
- ReqB  in  NUM_REQ*DATA_W  flattened operand B, same packing as ReqA
- ReqOp  in  NUM_REQ  per-requester op; 0 = EQ (result = A==B), 1 = NE (result = A!=B)
- RespValid  out  1  result valid
- RespReady  in  1  consumer accept
- RespId  out  ID_W  index of the requester that was served
- RespResult  out  1  compare result
- Busy  out  1  high whenever state != IDLE
- DoneCount  out  16  completed transactions; wraps at 0xFFFF -> 0

## Operation
- FSM states: IDLE, COMPARE, RESPOND.
- IDLE:
  - If any ReqValid is set, grant g = first set bit searching upward from Ptr, wrapping at NUM_REQ.
  - ReqReady[g]=1 in the same cycle.
  - On the clock edge, capture ReqA[g], ReqB[g], ReqOp[g] and g into operand registers, then go to COMPARE.
  - Ptr <= (g+1) mod NUM_REQ.
  - If no ReqValid is set, stay in IDLE with ReqReady all zero.
- COMPARE:
  - The comparator evaluates the captured operands.
  - RespResult <= eq XOR op, registered. RespId <= captured g.
  - Go to RESPOND.
- RESPOND:
  - RespValid=1. RespId and RespResult are held stable.
  - On RespValid && RespReady, go to IDLE and increment DoneCount.
  - Otherwise hold indefinitely.
- ReqReady is 0 in COMPARE and RESPOND. Requesters keep ReqValid and operands stable until they see ReqReady.
- ReqReady never depends on RespReady, so there is no combinational path from Resp to Req.
- Reset behaviour:
  - Reset values: state=IDLE, Ptr=0, RespValid=0, RespId=0, RespResult=0, DoneCount=0, Busy=0.
  - Reset asserted in COMPARE or RESPOND aborts the transaction. No response is produced and DoneCount is unchanged.
  - Reset has priority over every other event in the same cycle.

## Timing
- Accept-to-RespValid latency is 2 cycles: accept in cycle N, COMPARE in N+1, RespValid high in N+2.
- Minimum initiation interval is 3 cycles, because the response handshake and the next accept cannot fall in the same cycle.
- If RespReady is already high when RespValid rises, the handshake completes in that first RESPOND cycle. A new grant is then possible the following cycle.
- Simultaneous requests are served in round-robin order.
  - A requester that keeps ReqValid asserted waits at most NUM_REQ-1 other transactions.
  - Example: all four requesting with Ptr=0 gives order 0,1,2,3,0.
- A requester that deasserts ReqValid before its grant is skipped. No state is retained for it.
- Busy rises the cycle after accept and falls the cycle after the response handshake.

## Structure
- Shared package/header holds:
  - FSM state encodings (IDLE=2'd0, COMPARE=2'd1, RESPOND=2'd2).
  - Op constants OP_EQ=1'b0, OP_NE=1'b1.
  - Default widths.
- Sub-module rr_arbiter:
  - Inputs: request vector and Ptr. Output: one-hot grant plus encoded index.
  - Purely combinational, reusable by other shared-resource blocks.
- The datapath's existing 32-bit equality comparator (comparator_unit) is instantiated on the captured operand registers.
  - There is no second comparator.
  - The arbiter adds only the XOR with op.

## Test plan
- Reset mid-RESPOND with RespReady=0: RespValid=0 the next cycle, DoneCount stays at its prior value, ReqReady available again in IDLE.
- Single EQ: requester 2 sends A=B=0xDEADBEEF, op=0.
  - ReqReady[2] high in the accept cycle.
  - Two cycles later RespValid=1, RespId=2, RespResult=1.
  - DoneCount=1 after the handshake.
- Single NE: requester 1 sends A=0x00000001, B=0x80000001, op=1 -> RespResult=1. With A=B=0, op=1 -> RespResult=0.
- Fairness: all four ReqValid held high from reset, RespReady=1.
  - RespId sequence is 0,1,2,3,0.
  - One transaction completes every 3 cycles.
- Backpressure: RespReady=0 for 10 cycles in RESPOND.
  - RespValid, RespId and RespResult stay stable.
  - ReqReady stays 0 throughout.
  - Raising RespReady returns the FSM to IDLE on the next edge.
- DoneCount wrap: preload via 65535 transactions, or force in simulation; the next completion reads 0.

Source files
------------

// File: rtl/compare_arbiter_pkg.sv
// compare_arbiter_pkg: shared widths, FSM encodings and op constants for the compare arbiter
package compare_arbiter_pkg;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;
    localparam int ID_W    = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        RESPOND = 2'd2
    } state_t;

    localparam logic OP_EQ = 1'b0;
    localparam logic OP_NE = 1'b1;
endpackage

// File: rtl/compare_arbiter_if.sv
// compare_arbiter_if: request/response bundle between requesters, consumer and the arbiter
interface compare_arbiter_if;
    import compare_arbiter_pkg::*;
    logic [NUM_REQ-1:0]        ReqValid;
    logic [NUM_REQ-1:0]        ReqReady;
    logic [NUM_REQ*DATA_W-1:0] ReqA;
    logic [NUM_REQ*DATA_W-1:0] ReqB;
    logic [NUM_REQ-1:0]        ReqOp;
    logic                      RespValid;
    logic                      RespReady;
    logic [ID_W-1:0]           RespId;
    logic                      RespResult;
    logic                      Busy;
    logic [15:0]               DoneCount;

    modport master (
        output ReqValid, ReqA, ReqB, ReqOp, RespReady,
        input  ReqReady, RespValid, RespId, RespResult, Busy, DoneCount
    );
    modport slave (
        input  ReqValid, ReqA, ReqB, ReqOp, RespReady,
        output ReqReady, RespValid, RespId, RespResult, Busy, DoneCount
    );
endinterface

// File: rtl/comparator_unit.sv
// comparator_unit: the datapath's shared equality comparator
module comparator_unit #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_eq
);
    assign o_eq = i_a == i_b;
endmodule

// File: rtl/compare_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first request at or above i_ptr
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);
    int j;
    assign o_any = |i_req;
    // Scan lowest priority first so the highest-priority hit is the last write
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        j = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(i_ptr) + k) % N;
            if (i_req[j]) begin
                o_gnt = N'(1) << j;
                o_idx = IW'(j);
            end
        end
    end
endmodule

// File: rtl/compare_arbiter.sv
// compare_arbiter: round-robin sharing of one equality comparator, one tagged EQ/NE result per transaction
module compare_arbiter
    import compare_arbiter_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    compare_arbiter_if.slave bus
);
    state_t              r_state, w_next;
    logic [ID_W-1:0]     r_ptr, r_id, r_resp_id, w_idx;
    logic [NUM_REQ-1:0]  w_gnt;
    logic                w_any, w_eq, r_op, r_resp_res, w_accept, w_done;
    logic [DATA_W-1:0]   r_a, r_b;
    logic [15:0]         r_done_count;

    rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
        .i_req(bus.ReqValid), .i_ptr(r_ptr), .o_gnt(w_gnt), .o_idx(w_idx), .o_any(w_any)
    );
    comparator_unit #(.W(DATA_W)) u_cmp (.i_a(r_a), .i_b(r_b), .o_eq(w_eq));

    always_comb begin
        w_accept = (r_state == IDLE) && w_any;
        w_done   = (r_state == RESPOND) && bus.RespReady;
        w_next   = w_accept ? COMPARE :
                   (r_state == COMPARE) ? RESPOND :
                   w_done ? IDLE : r_state;
    end

    assign bus.ReqReady   = (r_state == IDLE) ? w_gnt : '0;
    assign bus.RespValid  = r_state == RESPOND;
    assign bus.RespId     = r_resp_id;
    assign bus.RespResult = r_resp_res;
    assign bus.Busy       = r_state != IDLE;
    assign bus.DoneCount  = r_done_count;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_resp_id    <= '0;
            r_resp_res   <= 1'b0;
            r_done_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a   <= bus.ReqA[w_idx*DATA_W +: DATA_W];
                r_b   <= bus.ReqB[w_idx*DATA_W +: DATA_W];
                r_op  <= bus.ReqOp[w_idx];
                r_id  <= w_idx;
                r_ptr <= (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
            end
            if (r_state == COMPARE) begin
                r_resp_res <= w_eq ^ r_op;
                r_resp_id  <= r_id;
            end
            if (w_done) r_done_count <= r_done_count + 16'd1;
        end
    end
endmodule
